bit_adj_16b_to_32b_stream: RTL and testbench



---
 rtl/bit_adj_16b_to_32b_stream.sv | 90 +++++++++
 tb/tb_bit_adj_16b_to_32b_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_adj_16b_to_32b_stream.sv
// Widens Q4.12 samples to Q8.24 through a 2-entry valid/ready buffer with a frame index counter.
// Optional macro BIT_ADJ_IDX_OUT_EN exposes the frame index as o_idx.
module bit_adj_16b_to_32b_stream #(
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [15:0]      i_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [31:0]      o_data,
  output logic             o_last
`ifdef BIT_ADJ_IDX_OUT_EN
  ,
  output logic [IDX_W-1:0] o_idx
`endif
);

  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(FRAME_LEN - 1);

  logic [31:0]      r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_ready;
  logic [IDX_W-1:0] r_idx;

  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_wide;
  logic [1:0]       w_count_nxt;

  assign w_push = i_valid & r_ready;
  assign w_pop  = o_valid & o_ready;
  // 4 guard bits of sign, 12 zero fraction bits: exact, no rounding needed
  assign w_wide = {{4{i_data[15]}}, i_data, 12'b0};

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
      r_idx    <= '0;
    end else if (i_clear) begin
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
      r_idx    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_wide;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        r_idx  <= (r_idx == LP_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      r_count <= w_count_nxt;
      // ready is precomputed from the next count so o_ready never reaches i_ready combinationally
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign i_ready = r_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_last  = o_valid & (r_idx == LP_IDX_LAST);

`ifdef BIT_ADJ_IDX_OUT_EN
  assign o_idx = r_idx;
`endif

endmodule

// File: tb/tb_bit_adj_16b_to_32b_stream.sv
// Self-checking bench for bit_adj_16b_to_32b_stream: vector table plus queue-model sequences.
module tb_bit_adj_16b_to_32b_stream;

  localparam int FRAME_LEN = 64;
  localparam int IDX_W     = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_clear = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [15:0]      i_data = '0;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic [31:0]      o_data;
  logic             o_last;
`ifdef BIT_ADJ_IDX_OUT_EN
  logic [IDX_W-1:0] o_idx;
`endif

  bit_adj_16b_to_32b_stream #(.FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_valid(i_valid), .i_ready(i_ready),
    .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last)
`ifdef BIT_ADJ_IDX_OUT_EN
    , .o_idx(o_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [31:0] exp;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_q[$];
  int          m_idx = 0;
  int          n_pops = 0;
  int          last_pops[$];
  logic [31:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] widen(input logic [15:0] d);
    logic signed [31:0] s;
    s = {{16{d[15]}}, d};
    return s <<< 12;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_clear = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_q.delete(); m_idx = 0; n_pops = 0; last_pops.delete(); popped.delete();
  endtask

  // One clock of stimulus, checked against the queue model before the edge.
  task automatic step(input logic clr, input logic v, input logic [15:0] d, input logic rdy);
    logic push, pop;
    i_clear = clr; i_valid = v; i_data = d; o_ready = rdy;
    #1;
    chk("i_ready", 32'(i_ready), 32'(m_q.size() < 2));
    chk("o_valid", 32'(o_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("o_data", o_data, m_q[0]);
      chk("o_last", 32'(o_last), 32'(m_idx == FRAME_LEN - 1));
`ifdef BIT_ADJ_IDX_OUT_EN
      chk("o_idx", 32'(o_idx), 32'(m_idx));
`endif
    end else begin
      chk("o_last_idle", 32'(o_last), 32'd0);
    end
    push = v && (m_q.size() < 2);
    pop  = rdy && (m_q.size() > 0);
    if (!clr && pop) begin
      if (o_last) last_pops.push_back(n_pops);
      popped.push_back(o_data);
    end
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    if (clr) begin
      m_q.delete();
      m_idx = 0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_idx = (m_idx + 1) % FRAME_LEN;
        n_pops++;
      end
      if (push) m_q.push_back(widen(d));
    end
  endtask

  task automatic chk_lasts(input string name, input int exp[$]);
    chk({name, "_cnt"}, 32'(last_pops.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < last_pops.size(); i++)
      chk({name, "_pos"}, 32'(last_pops[i]), 32'(exp[i]));
  endtask

  vec_t tbl[6];
  int   exp_l[$];
  int   cyc;

  initial begin
    tbl[0] = '{16'h7FFF, 32'h07FF_F000};
    tbl[1] = '{16'h8000, 32'hF800_0000};
    tbl[2] = '{16'h0001, 32'h0000_1000};
    tbl[3] = '{16'hFFFF, 32'hFFFF_F000};
    tbl[4] = '{16'h1234, 32'h0123_4000};
    tbl[5] = '{16'hC000, 32'hFC00_0000};

    do_reset();
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_last", 32'(o_last), 32'd0);
    chk("rst_o_data", o_data, 32'd0);

    // Widening table: value visible one cycle after push
    o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1; i_data = tbl[i].d;
      tick();
      i_valid = 1'b0;
      chk("wide_valid", 32'(o_valid), 32'd1);
      chk("wide_data", o_data, tbl[i].exp);
      tick();
      chk("wide_drained", 32'(o_valid), 32'd0);
    end

    // Backpressure: third sample held by source until space frees
    do_reset();
    step(1'b0, 1'b1, 16'h0A0A, 1'b0);
    step(1'b0, 1'b1, 16'h0B0B, 1'b0);
    chk("bp_full_ready", 32'(i_ready), 32'd0);
    step(1'b0, 1'b1, 16'h8C0C, 1'b0);
    step(1'b0, 1'b1, 16'h8C0C, 1'b1);
    step(1'b0, 1'b1, 16'h8C0C, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("bp_pop_cnt", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("bp_order0", popped[0], 32'h00A0_A000);
      chk("bp_order1", popped[1], 32'h00B0_B000);
      chk("bp_order2", popped[2], 32'hF8C0_C000);
    end

    // Streaming 200 cycles: o_last on outputs 63, 127, 191
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 16'(i * 37 + 5), 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("stream_pops", 32'(n_pops), 32'd200);
    exp_l = '{63, 127, 191};
    chk_lasts("stream_last", exp_l);

    // Clear with full buffer at idx 10, then random stall over 128 pops
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 16'(i + 1), 1'b1);
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    chk("clr_pre_full", 32'(i_ready), 32'd0);
    chk("clr_pre_valid", 32'(o_valid), 32'd1);
    step(1'b1, 1'b1, 16'h2222, 1'b1);
    chk("clr_o_valid", 32'(o_valid), 32'd0);
    chk("clr_i_ready", 32'(i_ready), 32'd1);
    n_pops = 0; last_pops.delete();
    cyc = 0;
    while (n_pops < 128 && cyc < 3000) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    chk("stall_done", 32'(n_pops >= 128), 32'd1);
    exp_l = '{63, 127};
    chk_lasts("stall_last", exp_l);

    // Async reset between edges with o_last high
    do_reset();
    cyc = 0;
    while (n_pops < 63 && cyc < 200) begin
      step(1'b0, 1'b1, 16'(16'h0100 + cyc), 1'b1);
      cyc++;
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("arst_pre_last", 32'(o_last), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", 32'(o_valid), 32'd0);
    chk("arst_o_last", 32'(o_last), 32'd0);
    chk("arst_o_data", o_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_q.delete(); m_idx = 0; n_pops = 0; last_pops.delete();
    chk("arst_i_ready", 32'(i_ready), 32'd1);
    for (int i = 0; i < 66; i++) step(1'b0, 1'b1, 16'(i), 1'b1);
    exp_l = '{63};
    chk_lasts("arst_last", exp_l);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
